// File: rtl/slv_guard_cfg_pkg.sv
// Shared types and register map for the guard configuration sequencer.
// SLV_GUARD_CFG_READBACK_EN adds the READ/CHECK states used for write verification.
package slv_guard_cfg_pkg;

    localparam logic [31:0] ENABLE_OFFSET = 32'h0000_0000;
    localparam logic [31:0] BUDGET_STRIDE = 32'h0000_0004;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
`ifdef SLV_GUARD_CFG_READBACK_EN
        READ  = 3'd2,
        CHECK = 3'd3,
`endif
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } cfg_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } cfg_reg_rsp_t;

    // Index 0 is the enable register; budget i sits at stride*i.
    function automatic logic [31:0] budget_offset(input logic [31:0] idx);
        return (idx == 32'd0) ? ENABLE_OFFSET : BUDGET_STRIDE * idx;
    endfunction

endpackage

// File: rtl/slv_guard_cfg_timer.sv
// Ready-wait counter: counts cycles a request is pending and flags the last allowed one.
module slv_guard_cfg_timer #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_r;

    // Wait counter, cleared whenever no request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (srst) begin
            cnt_r <= '0;
        end else if (run && (cnt_r != Limit)) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = run && (cnt_r == Limit);

endmodule

// File: rtl/slv_guard_cfg_seq.sv
// Writes the guard enable and budget registers over a register bus, with timeout and error abort.
// Build option: SLV_GUARD_CFG_READBACK_EN verifies every write with a readback.
module slv_guard_cfg_seq
    import slv_guard_cfg_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          NumBudgets    = 10,
    parameter logic [AddrWidth-1:0] BaseAddr      = 32'h0,
    parameter int unsigned          TimeoutCycles = 64,
    parameter type                  reg_req_t     = slv_guard_cfg_pkg::cfg_reg_req_t,
    parameter type                  reg_rsp_t     = slv_guard_cfg_pkg::cfg_reg_rsp_t
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  start_i,
    input  logic [NumBudgets-1:0][DataWidth-1:0]  budgets_i,
    output reg_req_t                              reg_req_o,
    input  reg_rsp_t                              reg_rsp_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  error_o,
    output logic                                  timeout_o,
    output logic [$clog2(NumBudgets+1)-1:0]       err_idx_o
);

    localparam int unsigned     IdxW    = $clog2(NumBudgets + 1);
    localparam int unsigned     StrbW   = DataWidth / 8;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBudgets);

    state_e                               state_r;
    logic [IdxW-1:0]                      idx_r;
    logic [IdxW-1:0]                      err_idx_r;
    logic [NumBudgets-1:0][DataWidth-1:0] snap_r;
    logic                                 valid_r;
    logic                                 write_r;
    logic [AddrWidth-1:0]                 addr_r;
    logic [DataWidth-1:0]                 wdata_r;
    logic [StrbW-1:0]                     wstrb_r;
    logic                                 busy_r;
    logic                                 done_r;
    logic                                 error_r;
    logic                                 timeout_r;
`ifdef SLV_GUARD_CFG_READBACK_EN
    logic [DataWidth-1:0]                 rdata_r;
`endif
    logic [AddrWidth-1:0]                 addr_s;
    logic [DataWidth-1:0]                 data_s;
    logic                                 timer_srst_s;
    logic                                 timer_run_s;
    logic                                 timer_expired_s;
    reg_req_t                             req_s;

    assign addr_s       = BaseAddr + AddrWidth'(budget_offset(32'(idx_r)));
    assign timer_run_s  = valid_r && !reg_rsp_i.ready;
    assign timer_srst_s = !valid_r;

    // Payload for the current index: the enable value, then the snapshotted budgets.
    always_comb begin
        data_s = DataWidth'(1);
        for (int i = 0; i < NumBudgets; i++) begin
            data_s = (idx_r == IdxW'(i + 1)) ? snap_r[i] : data_s;
        end
    end

    slv_guard_cfg_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .srst   (timer_srst_s),
        .run    (timer_run_s),
        .expired(timer_expired_s)
    );

    // Sequencer FSM; a request is raised one cycle after entering an access so valid always drops in between.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            err_idx_r <= '0;
            snap_r    <= '0;
            valid_r   <= 1'b0;
            write_r   <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            timeout_r <= 1'b0;
`ifdef SLV_GUARD_CFG_READBACK_EN
            rdata_r   <= '0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        snap_r    <= budgets_i;
                        done_r    <= 1'b0;
                        error_r   <= 1'b0;
                        timeout_r <= 1'b0;
                        idx_r     <= '0;
                        busy_r    <= 1'b1;
                        state_r   <= WRITE;
                    end
                end
                WRITE: begin
                    if (!valid_r) begin
                        valid_r <= 1'b1;
                        write_r <= 1'b1;
                        addr_r  <= addr_s;
                        wdata_r <= data_s;
                        wstrb_r <= '1;
                    end else if (reg_rsp_i.ready) begin
                        valid_r <= 1'b0;
                        if (reg_rsp_i.error) begin
                            state_r   <= ERR;
                            busy_r    <= 1'b0;
                            error_r   <= 1'b1;
                            err_idx_r <= idx_r;
`ifdef SLV_GUARD_CFG_READBACK_EN
                        end else begin
                            state_r <= READ;
                        end
`else
                        end else if (idx_r == LastIdx) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            idx_r <= idx_r + 1'b1;
                        end
`endif
                    end else if (timer_expired_s) begin
                        valid_r   <= 1'b0;
                        state_r   <= ERR;
                        busy_r    <= 1'b0;
                        error_r   <= 1'b1;
                        timeout_r <= 1'b1;
                        err_idx_r <= idx_r;
                    end
                end
`ifdef SLV_GUARD_CFG_READBACK_EN
                READ: begin
                    if (!valid_r) begin
                        valid_r <= 1'b1;
                        write_r <= 1'b0;
                    end else if (reg_rsp_i.ready) begin
                        valid_r <= 1'b0;
                        rdata_r <= reg_rsp_i.rdata;
                        if (reg_rsp_i.error) begin
                            state_r   <= ERR;
                            busy_r    <= 1'b0;
                            error_r   <= 1'b1;
                            err_idx_r <= idx_r;
                        end else begin
                            state_r <= CHECK;
                        end
                    end else if (timer_expired_s) begin
                        valid_r   <= 1'b0;
                        state_r   <= ERR;
                        busy_r    <= 1'b0;
                        error_r   <= 1'b1;
                        timeout_r <= 1'b1;
                        err_idx_r <= idx_r;
                    end
                end
                CHECK: begin
                    if (rdata_r != wdata_r) begin
                        state_r   <= ERR;
                        busy_r    <= 1'b0;
                        error_r   <= 1'b1;
                        err_idx_r <= idx_r;
                    end else if (idx_r == LastIdx) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        idx_r   <= idx_r + 1'b1;
                        state_r <= WRITE;
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Bus request assembled from the registered fields.
    always_comb begin
        req_s       = '0;
        req_s.valid = valid_r;
        req_s.write = write_r;
        req_s.addr  = addr_r;
        req_s.wdata = wdata_r;
        req_s.wstrb = wstrb_r;
    end

    assign reg_req_o = req_s;
    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign error_o   = error_r;
    assign timeout_o = timeout_r;
    assign err_idx_o = err_idx_r;

endmodule

// File: tb/tb_slv_guard_cfg_seq.sv
// Directed bench for slv_guard_cfg_seq with a scoreboard of expected bus writes.
module tb_slv_guard_cfg_seq;
    import slv_guard_cfg_pkg::*;

    localparam int          NB   = 10;
    localparam int          TO   = 64;
    localparam logic [31:0] BASE = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    start = 1'b0;
    logic [NB-1:0][31:0]     budgets;
    cfg_reg_req_t            req;
    cfg_reg_rsp_t            rsp;
    logic                    busy, done, error, timeout;
    logic [3:0]              err_idx;

    exp_t                    sbq[$];
    exp_t                    mon_e;
    int                      tests = 0;
    int                      fails = 0;
    int                      never_ready = 0;
    int                      delay_idx = -1;
    int                      delay_cycles = 0;
    int                      err_inj = -1;
    int                      corrupt_idx = -1;
    int                      vcnt = 0;
    int                      vhigh = 0;
    int                      cur_idx;
    int                      n;
    logic [31:0]             mem [0:NB];
    logic [31:0]             last_waddr = 32'h0;
    cfg_reg_req_t            prev_req;
    logic                    prev_pending = 1'b0;

    always #5 clk = ~clk;

    slv_guard_cfg_seq #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .NumBudgets   (NB),
        .BaseAddr     (BASE),
        .TimeoutCycles(TO),
        .reg_req_t    (cfg_reg_req_t),
        .reg_rsp_t    (cfg_reg_rsp_t)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .start_i  (start),
        .budgets_i(budgets),
        .reg_req_o(req),
        .reg_rsp_i(rsp),
        .busy_o   (busy),
        .done_o   (done),
        .error_o  (error),
        .timeout_o(timeout),
        .err_idx_o(err_idx)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model: combinational ready/error/rdata controlled by the test knobs.
    always_comb begin
        cur_idx = int'((req.addr - BASE) >> 2);
        rsp = '0;
        if (req.valid && never_ready == 0) begin
            if (cur_idx == delay_idx) rsp.ready = (vcnt >= delay_cycles);
            else rsp.ready = 1'b1;
        end
        rsp.error = rsp.ready && req.write && (cur_idx == err_inj);
        if (cur_idx >= 0 && cur_idx <= NB)
            rsp.rdata = mem[cur_idx] ^ ((cur_idx == corrupt_idx) ? 32'h1 : 32'h0);
    end

    always @(posedge clk) begin
        if (req.valid && !rsp.ready) vcnt <= vcnt + 1;
        else vcnt <= 0;
        if (req.valid && rsp.ready && req.write && cur_idx >= 0 && cur_idx <= NB)
            mem[cur_idx] <= req.wdata;
    end

    // Monitor: request stability while pending, scoreboard on completed writes.
    always @(negedge clk) begin
        if (req.valid) vhigh++;
        if (prev_pending && req.valid) chk("req_stable", req, prev_req);
        if (req.valid && rsp.ready) begin
            if (req.write) begin
                chk("access_expected", sbq.size() > 0, 1'b1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    chk("wr_addr", req.addr, mon_e.addr);
                    chk("wr_data", req.wdata, mon_e.data);
                    chk("wr_strb", req.wstrb, 4'hF);
                end
                last_waddr = req.addr;
            end else begin
                chk("rd_addr", req.addr, last_waddr);
            end
        end
        prev_pending = req.valid && !rsp.ready;
        prev_req = req;
    end

    task automatic push_run();
        exp_t e;
        for (int i = 0; i <= NB; i++) begin
            e.addr = BASE + 32'(4 * i);
            if (i == 0) e.data = 32'd1;
            else e.data = budgets[i-1];
            sbq.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        push_run();
        vhigh = 0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input int max);
        int k;
        k = 0;
        while (!(done || error) && k < max) begin
            @(posedge clk);
            #1 k++;
        end
        chk("run_end_bound", done || error, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_timeout"}, timeout, 1'b0);
        chk({tag, "_err_idx"}, err_idx, 4'd0);
        chk({tag, "_req"}, req, 128'h0);
    endtask

    initial begin
        for (int i = 0; i < NB; i++) budgets[i] = $urandom;
        for (int i = 0; i <= NB; i++) mem[i] = 32'h0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_ni = 1'b1;

        // Always-ready run; inputs changed after start must not leak in.
        pulse_start();
        chk("busy_run", busy, 1'b1);
        for (int i = 0; i < NB; i++) budgets[i] = ~budgets[i];
        n = 1;
        while (!done && n < 300) begin
            @(posedge clk);
            #1 n++;
            if (n == 22) chk("done_early", done, 1'b0);
        end
`ifndef SLV_GUARD_CFG_READBACK_EN
        chk("done_latency", n, 23);
        chk("valid_cycles", vhigh, 11);
`else
        chk("valid_cycles", vhigh, 22);
`endif
        chk("t1_done", done, 1'b1);
        chk("t1_error", error, 1'b0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_queue", sbq.size(), 0);

        // Ready delayed 5 cycles on index 3, plus a start pulse while busy.
        delay_idx = 3;
        delay_cycles = 5;
        pulse_start();
        repeat (4) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_end(300);
`ifndef SLV_GUARD_CFG_READBACK_EN
        chk("t2_valid_cycles", vhigh, 16);
`else
        chk("t2_valid_cycles", vhigh, 32);
`endif
        chk("t2_done", done, 1'b1);
        chk("t2_error", error, 1'b0);
        chk("t2_queue", sbq.size(), 0);
        delay_idx = -1;

        // Slave error on index 4.
        err_inj = 4;
        pulse_start();
        wait_end(300);
        chk("t3_error", error, 1'b1);
        chk("t3_err_idx", err_idx, 4'd4);
        chk("t3_timeout", timeout, 1'b0);
        chk("t3_done", done, 1'b0);
        chk("t3_busy", busy, 1'b0);
        repeat (20) @(posedge clk);
        #1 chk("t3_no_more_access", sbq.size(), 6);
        sbq.delete();
        err_inj = -1;

        // Slave never ready: timeout on index 0.
        never_ready = 1;
        pulse_start();
        wait_end(300);
        chk("t4_error", error, 1'b1);
        chk("t4_timeout", timeout, 1'b1);
        chk("t4_err_idx", err_idx, 4'd0);
        chk("t4_done", done, 1'b0);
        chk("t4_valid_cycles", vhigh, TO);
        repeat (5) @(posedge clk);
        #1 chk("t4_valid_dropped", vhigh, TO);
        sbq.delete();
        never_ready = 0;

        // Reset while index 5 is pending, then a clean restart.
        delay_idx = 5;
        delay_cycles = 1000;
        pulse_start();
        n = 0;
        while (!(req.valid && req.addr == BASE + 32'd20) && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("t5_reached_idx5", req.valid && req.addr == BASE + 32'd20, 1'b1);
        #2 rst_ni = 1'b0;
        #1 chk_all_zero("t5_async_reset");
        @(negedge clk) rst_ni = 1'b1;
        sbq.delete();
        delay_idx = -1;
        pulse_start();
        wait_end(300);
        chk("t5_done", done, 1'b1);
        chk("t5_error", error, 1'b0);
        chk("t5_queue", sbq.size(), 0);

`ifdef SLV_GUARD_CFG_READBACK_EN
        // Corrupted readback on index 2.
        corrupt_idx = 2;
        pulse_start();
        wait_end(300);
        chk("t6_error", error, 1'b1);
        chk("t6_err_idx", err_idx, 4'd2);
        chk("t6_timeout", timeout, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_queue", sbq.size(), 8);
        sbq.delete();
        corrupt_idx = -1;
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/slv_guard_cfg_seq.md
SLV_GUARD_CFG_SEQ -- requirements
Module: slv_guard_cfg_seq

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, register-bus address width.
REQ-002 SHALL have parameter DataWidth, default 32, register-bus data width.
REQ-003 SHALL have parameter NumBudgets, default 10, number of budget registers.
REQ-004 SHALL have parameter BaseAddr, default 32'h0, address of the guard enable register.
REQ-005 SHALL have parameter TimeoutCycles, default 64, maximum wait for ready per access.
REQ-006 SHALL have type parameters reg_req_t and reg_rsp_t, register-bus request and response structs.
REQ-007 SHALL have clk_i, input, 1, the single clock.
REQ-008 SHALL have rst_ni, input, 1, asynchronous active-low reset.
REQ-009 SHALL have start_i, input, 1, single-cycle pulse that starts a configuration run.
REQ-010 SHALL have budgets_i, input, NumBudgets x DataWidth, budget values.
REQ-011 SHALL have reg_req_o, output, reg_req_t, register-bus request.
REQ-012 SHALL have reg_rsp_i, input, reg_rsp_t, register-bus response.
REQ-013 SHALL have busy_o, output, 1, run in progress.
REQ-014 SHALL have done_o, output, 1, last run completed without error.
REQ-015 SHALL have error_o, output, 1, last run aborted.
REQ-016 SHALL have timeout_o, output, 1, the abort was caused by a timeout.
REQ-017 SHALL have err_idx_o, output, $clog2(NumBudgets+1), index of the failing access.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, [READ, CHECK], DONE, ERR.
REQ-019 SHALL, on start_i in IDLE/DONE/ERR, snapshot budgets_i, clear done_o/error_o/timeout_o, and enter WRITE at index 0 in the next cycle.
REQ-020 SHALL ignore start_i while busy_o=1.
REQ-021 SHALL, for index 0, write data 1 to BaseAddr; for index i (1..NumBudgets), write snapshot[i-1] to BaseAddr+4*i.
REQ-022 SHALL use wstrb all-ones and write=1 for every write.
REQ-023 SHALL hold valid, addr, wdata, wstrb and write stable until valid&&ready.
REQ-024 SHALL drop valid for at least one cycle between accesses.
REQ-025 SHALL complete an access on the cycle valid&&ready, sampling error in that same cycle.
REQ-026 SHALL, on a completed access with error=1, enter ERR, set error_o=1 and set err_idx_o to the current index.
REQ-027 SHALL count waiting cycles from the first valid cycle of each access.
REQ-028 SHALL, when the wait count reaches TimeoutCycles without ready, deassert valid, enter ERR, and set error_o=1, timeout_o=1 and err_idx_o.
REQ-029 SHALL, after index NumBudgets completes without error, enter DONE and set done_o=1.
REQ-030 SHALL hold done_o and error_o until the next start_i or reset.
REQ-031 SHALL assert busy_o exactly in WRITE, READ and CHECK.
REQ-032 SHALL take exactly 2*(NumBudgets+1)+1 cycles from start_i to done_o when ready is combinational.

Reset
REQ-033 SHALL, when rst_ni=0, asynchronously set the state to IDLE, all outputs and request fields to 0, and clear the counters and snapshot, including mid-run.

Configuration
REQ-034 SHALL, with SLV_GUARD_CFG_READBACK_EN defined, follow each accepted write with a read of the same address (READ state) and compare rdata to the written data (CHECK state).
REQ-035 SHALL treat a readback mismatch or read error exactly like a write error under SLV_GUARD_CFG_READBACK_EN.
REQ-036 SHALL, without SLV_GUARD_CFG_READBACK_EN, compile no READ/CHECK logic and go from WRITE directly to the next index.

Structure
REQ-037 SHALL place the state enum and the register offset constants (enable at 0x0, budget stride 4) in package slv_guard_cfg_pkg.
REQ-038 SHALL implement the ready-timeout counter as sub-module slv_guard_cfg_timer.

Verification
REQ-039 SHALL cover: NumBudgets=10 and an always-ready slave, start_i -> writes 0x0=1, then 0x4..0x28 carrying budgets; done_o=1 after 23 cycles.
REQ-040 SHALL cover: ready delayed 5 cycles on index 3 -> request held stable for all 5 cycles; run completes; done_o=1.
REQ-041 SHALL cover: error=1 on index 4 -> error_o=1, err_idx_o=4, timeout_o=0, no further accesses.
REQ-042 SHALL cover: ready never asserted and TimeoutCycles=64 -> valid dropped after 64 cycles; error_o=1, timeout_o=1, err_idx_o=0.
REQ-043 SHALL cover: rst_ni=0 during index 5 -> all outputs 0 immediately; a later start_i restarts from index 0.
REQ-044 SHALL cover: with READBACK_EN and rdata corrupted at index 2 -> error_o=1, err_idx_o=2.
